// File: rtl/uart_tx_serializer.sv
// Byte FIFO feeding an 8N1 UART transmitter; define UART_TX_PARITY_EN for 8E1 frames.
// Frames go out back to back while bytes are queued.
module uart_tx_serializer #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                             i_clk,
    input  logic                             i_reset_n,
    input  logic [7:0]                       i_data,
    input  logic                             i_valid,
    output logic                             o_ready,
    output logic                             o_tx,
    output logic                             o_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_fifo_count
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_q, bit_d;
    logic [BW-1:0] baud_q, baud_d;
    logic          tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic          baud_last;
    logic [7:0]    head;

    assign o_ready      = (count_q != CW'(FIFO_DEPTH));
    assign push         = i_valid && o_ready;
    assign fifo_empty   = (count_q == '0);
    assign head         = mem_q[rd_ptr_q];
    assign baud_last    = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign o_tx         = tx_q;
    assign o_busy       = (state_q != S_IDLE) || !fifo_empty;
    assign o_fifo_count = count_q;

    // Storage is not reset: only pointers and count define occupancy.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        baud_d   = baud_q + BW'(1);
        pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    shift_d  = head;
                    bit_d    = '0;
                    state_d  = S_START;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^head;
`endif
                end
            end
            S_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        shift_d  = head;
                        bit_d    = '0;
                        state_d  = S_START;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^head;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = S_IDLE;
            end
        endcase

        // Line level is registered, so it is decoded from the next state.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            shift_q  <= '0;
            bit_q    <= '0;
            baud_q   <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            baud_q   <= baud_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule
